// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the four-source serial frame transmitter.
package serial_frame_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned PORT_W = 2;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PORT,
        LEN,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/data bundle and serial line of the frame transmitter.
interface serial_frame_tx_if;
    import serial_frame_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*LEN_W-1:0]  len;
    logic [N_REQ*DATA_W-1:0] data;
    logic                    SerOut;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic                    Done;

    modport master (output req, len, data, input SerOut, gnt, busy, Done);
    modport slave  (input req, len, data, output SerOut, gnt, busy, Done);
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick starting at ptr.
module rr_arbiter4
    import serial_frame_pkg::*;
(
    input  logic [N_REQ-1:0]  req,
    input  logic [PORT_W-1:0] ptr,
    output logic              valid,
    output logic [PORT_W-1:0] idx,
    output logic [N_REQ-1:0]  sel
);

    logic [PORT_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest active source to ptr wins.
    always_comb begin
        valid  = 1'b0;
        idx    = ptr;
        sel    = '0;
        w_cand = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = ptr + PORT_W'(k);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
        if (valid) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Round-robin scheduler and serial framer: start, port id, length, data, stop.
module serial_frame_tx
    import serial_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    serial_frame_tx_if.slave bus
);

    state_t              r_state;
    logic [PORT_W-1:0]   r_ptr;
    logic [PORT_W-1:0]   r_idx;
    logic [LEN_W-1:0]    r_len;
    logic [DATA_W-1:0]   r_data;
    logic [LEN_W-1:0]    r_fld;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ser;
    logic [N_REQ-1:0]    r_gnt;
    logic                r_busy;
    logic                r_done;

    logic                w_valid;
    logic [PORT_W-1:0]   w_idx;
    logic [N_REQ-1:0]    w_sel;

    rr_arbiter4 u_arb (
        .req   (bus.req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx),
        .sel   (w_sel)
    );

    // Frame sequencer; r_fld shifts the header fields MSB first, r_data the payload LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_data  <= '0;
            r_fld   <= '0;
            r_cnt   <= '0;
            r_ser   <= IDLE_LVL;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            if (clkEn) begin
                case (r_state)
                    IDLE: begin
                        r_ser <= IDLE_LVL;
                        if (w_valid) begin
                            r_idx   <= w_idx;
                            r_len   <= bus.len[{w_idx, 2'b00} +: LEN_W];
                            r_data  <= bus.data[{w_idx, 4'b0000} +: DATA_W];
                            r_ptr   <= w_idx + PORT_W'(1);
                            r_gnt   <= w_sel;
                            r_busy  <= 1'b1;
                            r_ser   <= START_BIT;
                            r_state <= START;
                        end
                    end
                    START: begin
                        r_ser   <= r_idx[1];
                        r_fld   <= {r_idx[0], 3'b000};
                        r_cnt   <= CNT_W'(1);
                        r_state <= PORT;
                    end
                    PORT: begin
                        if (r_cnt != '0) begin
                            r_ser <= r_fld[LEN_W-1];
                            r_fld <= {r_fld[LEN_W-2:0], 1'b0};
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else begin
                            r_ser   <= r_len[LEN_W-1];
                            r_fld   <= {r_len[LEN_W-2:0], 1'b0};
                            r_cnt   <= CNT_W'(3);
                            r_state <= LEN;
                        end
                    end
                    LEN: begin
                        if (r_cnt != '0) begin
                            r_ser <= r_fld[LEN_W-1];
                            r_fld <= {r_fld[LEN_W-2:0], 1'b0};
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else if (r_len != '0) begin
                            r_ser   <= r_data[0];
                            r_data  <= {1'b0, r_data[DATA_W-1:1]};
                            r_cnt   <= r_len - CNT_W'(1);
                            r_state <= DATA;
                        end else begin
                            r_ser   <= IDLE_LVL;
                            r_state <= STOP;
                        end
                    end
                    DATA: begin
                        if (r_cnt != '0) begin
                            r_ser  <= r_data[0];
                            r_data <= {1'b0, r_data[DATA_W-1:1]};
                            r_cnt  <= r_cnt - CNT_W'(1);
                        end else begin
                            r_ser   <= IDLE_LVL;
                            r_state <= STOP;
                        end
                    end
                    STOP: begin
                        r_ser   <= IDLE_LVL;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_ser   <= IDLE_LVL;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.SerOut = r_ser;
    assign bus.gnt    = r_gnt;
    assign bus.busy   = r_busy;
    assign bus.Done   = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: directed frames, monitor decodes the line.
module tb_serial_frame_tx;

    typedef struct {
        logic [3:0]  gnt;
        logic [31:0] bits;
        int          nbits;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic clkEn;
    logic en_q;
    int   en_div;
    int   en_phase;

    serial_frame_tx_if bus ();

    serial_frame_tx dut (
        .clk   (clk),
        .rst   (rst),
        .clkEn (clkEn),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    // Monitor state
    bit          in_frame;
    int          nb;
    int          cyc;
    logic [31:0] cap;
    exp_t        cur;
    bit          gnt_prev;
    bit          done_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-rate enable generator: high every en_div-th clock.
    always begin
        @(posedge clk);
        #1;
        en_phase = (en_phase + 1) % en_div;
        clkEn    = (en_phase == 0);
    end

    always @(posedge clk) en_q <= clkEn;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Decode the serial line between a grant and the following Done.
    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            gnt_prev  = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (gnt_prev)  check("gnt_width", 32'(bus.gnt), 32'd0);
            if (done_prev) check("done_width", 32'(bus.Done), 32'd0);
            if (in_frame) cyc++;
            if (bus.Done) begin
                if (!in_frame) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    check("frame_len", 32'(nb), 32'(cur.nbits));
                    check("frame_bits", cap, cur.bits);
                    check("frame_cycles", 32'(cyc), 32'(cur.cyc));
                    check("busy_end", 32'(bus.busy), 32'd0);
                    check("idle_level", 32'(bus.SerOut), 32'd1);
                end
                in_frame = 1'b0;
            end else if (in_frame && en_q) begin
                cap = {cap[30:0], bus.SerOut};
                nb++;
            end
            if (bus.gnt != '0) begin
                if (sb.size() == 0) begin
                    check("gnt_unexpected", 32'(bus.gnt), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("gnt_onehot", 32'(bus.gnt), 32'(cur.gnt));
                    check("busy_start", 32'(bus.busy), 32'd1);
                end
                in_frame = 1'b1;
                cap      = {31'd0, bus.SerOut};
                nb       = 1;
                cyc      = 0;
            end
            gnt_prev  = (bus.gnt != '0);
            done_prev = bus.Done;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [31:0] bits, input int nbits, input int cy);
        exp_t e;
        e.gnt   = g;
        e.bits  = bits;
        e.nbits = nbits;
        e.cyc   = cy;
        sb.push_back(e);
    endtask

    task automatic wait_gnt();
        int k;
        k = 0;
        while (bus.gnt == '0 && k < 200) begin
            tick(1);
            k++;
        end
        if (bus.gnt == '0) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.Done && k < 300) begin
            tick(1);
            k++;
        end
        if (!bus.Done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        en_div   = 1;
        en_phase = 0;
        clkEn    = 1'b0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.len  = '0;
        bus.data = '0;
        tick(3);

        // Reset state
        check("rst_serout", 32'(bus.SerOut), 32'd1);
        check("rst_gnt",    32'(bus.gnt),    32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.Done),   32'd0);
        rst = 1'b0;
        tick(2);

        // Single frame: source 0, L=3, data 101
        bus.len[3:0]   = 4'd3;
        bus.data[15:0] = 16'h0005;
        push(4'b0001, 32'b00000111011, 11, 11);
        bus.req = 4'b0001;
        wait_gnt();
        bus.req = '0;
        wait_done();
        tick(3);

        // Zero length: source 2
        bus.len[11:8]   = 4'd0;
        bus.data[47:32] = 16'hFFFF;
        push(4'b0100, 32'b01000001, 8, 8);
        bus.req = 4'b0100;
        wait_gnt();
        bus.req = '0;
        wait_done();
        tick(3);

        // Fairness: all four requesting, L=1, data bit = source index LSB
        do_reset();
        bus.len  = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.data = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        push(4'b0001, 32'b000000101, 9, 9);
        push(4'b0010, 32'b001000111, 9, 9);
        push(4'b0100, 32'b010000101, 9, 9);
        push(4'b1000, 32'b011000111, 9, 9);
        push(4'b0001, 32'b000000101, 9, 9);
        bus.req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_done();
            if (f < 4) tick(1);
        end
        bus.req = '0;
        tick(4);

        // Enable stretching: bits held for three clocks
        en_div = 3;
        bus.len[3:0]   = 4'd3;
        bus.data[15:0] = 16'h0005;
        push(4'b0001, 32'b00000111011, 11, 33);
        bus.req = 4'b0001;
        wait_gnt();
        bus.req = '0;
        wait_done();
        tick(6);
        en_div = 1;
        tick(3);

        // Reset mid-frame from source 2, then re-arbitrate from ptr=0
        do_reset();
        bus.len[11:8]   = 4'd5;
        bus.data[47:32] = 16'h0013;
        bus.len[15:12]  = 4'd2;
        push(4'b0100, 32'd0, 0, 0);
        bus.req = 4'b1100;
        wait_gnt();
        tick(8);
        rst = 1'b1;
        #1;
        check("abort_serout", 32'(bus.SerOut), 32'd1);
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_done",   32'(bus.Done),   32'd0);
        tick(2);
        push(4'b0100, 32'b0100101110011, 13, 13);
        rst = 1'b0;
        wait_gnt();
        bus.req = '0;
        wait_done();
        tick(3);

        // Input isolation: source 0 inputs change during LEN
        bus.len[3:0]   = 4'd6;
        bus.data[15:0] = 16'h002D;
        push(4'b0001, 32'b00001101011011, 14, 14);
        bus.req = 4'b0001;
        wait_gnt();
        bus.req = '0;
        tick(4);
        bus.len[3:0]   = 4'd2;
        bus.data[15:0] = 16'hFFFF;
        wait_done();
        tick(20);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
